// File: rtl/lcd_refresh_driver.sv
// HD44780 4-bit character-LCD driver: power-on init, then endless refresh of
// both 16-character lines from an upstream character map addressed by index.
module lcd_refresh_driver #(
  parameter int T_PWR   = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_CMD   = 2000,
  parameter int T_CLEAR = 82000,
  parameter int T_SETUP = 2,
  parameter int T_EHIGH = 12,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char,
  output logic [7:0] index,
  output logic       rs,
  output logic       rw,
  output logic       enable,
  output logic [3:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam int CNT_MAX0 = (T_PWR > T_CMD + T_CLEAR) ? T_PWR : T_CMD + T_CLEAR;
  localparam int CNT_MAX  = (CNT_MAX0 > T_INIT1) ? CNT_MAX0 : T_INIT1;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_INIT_NIB, S_CFG_BYTE, S_ADDR1,
    S_LINE1, S_ADDR2, S_LINE2, S_FRAME_END
  } state_t;

  typedef enum logic [2:0] {
    PH_SETUP, PH_EHIGH, PH_HOLD, PH_GAP, PH_WAIT
  } phase_t;

  state_t           state_q, state_n, tgt_state;
  phase_t           phase_q, phase_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [3:0]       item_q, item_n, tgt_item;
  logic             upper_q, upper_n;
  logic             pass_q, pass_n;
  logic             rs_q, rs_n;
  logic             enable_q, enable_n;
  logic [7:0]       byte_q, byte_n;
  logic [7:0]       index_q, index_n;
  logic             init_done_q, init_done_n;
  logic             frame_done_q, frame_done_n;
  logic             launch;

  function automatic logic [7:0] cmd_byte(input state_t s, input logic [3:0] item);
    case (s)
      S_INIT_NIB: return (item == 4'd3) ? 8'h20 : 8'h30;
      S_CFG_BYTE: begin
        case (item[1:0])
          2'd0:    return 8'h28;
          2'd1:    return 8'h06;
          2'd2:    return 8'h0C;
          default: return 8'h01;
        endcase
      end
      S_ADDR1: return 8'h80;
      S_ADDR2: return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  // Returns the post-write wait minus one (down-counter reload value).
  // The final line-2 wait is one cycle short because FRAME_END supplies the
  // last idle cycle, keeping the frame exactly 34 byte-times (needs T_CMD >= 2).
  function automatic logic [CNT_W-1:0] wait_len(input state_t s, input logic [3:0] item);
    case (s)
      S_INIT_NIB: begin
        case (item)
          4'd0:    return CNT_W'(T_INIT1 - 1);
          4'd1:    return CNT_W'(T_INIT2 - 1);
          default: return CNT_W'(T_CMD - 1);
        endcase
      end
      S_CFG_BYTE: return (item == 4'd3) ? CNT_W'(T_CMD + T_CLEAR - 1) : CNT_W'(T_CMD - 1);
      S_LINE2:    return (item == 4'hF) ? CNT_W'(T_CMD - 2) : CNT_W'(T_CMD - 1);
      default:    return CNT_W'(T_CMD - 1);
    endcase
  endfunction

  always_comb begin
    state_n      = state_q;
    phase_n      = phase_q;
    cnt_n        = cnt_q;
    item_n       = item_q;
    upper_n      = upper_q;
    pass_n       = pass_q;
    rs_n         = rs_q;
    enable_n     = enable_q;
    byte_n       = byte_q;
    index_n      = index_q;
    init_done_n  = init_done_q;
    frame_done_n = 1'b0;
    launch       = 1'b0;
    tgt_state    = state_q;
    tgt_item     = item_q;

    if (state_q == S_PWR_WAIT) begin
      if (cnt_q == '0) begin
        launch    = 1'b1;
        tgt_state = S_INIT_NIB;
        tgt_item  = 4'd0;
      end else begin
        cnt_n = cnt_q - CNT_W'(1);
      end
    end else if (state_q == S_FRAME_END) begin
      launch    = 1'b1;
      tgt_state = S_ADDR1;
      tgt_item  = 4'd0;
    end else begin
      case (phase_q)
        PH_SETUP: begin
          if (cnt_q == '0) begin
            phase_n  = PH_EHIGH;
            cnt_n    = CNT_W'(T_EHIGH - 1);
            enable_n = 1'b1;
            // Character byte: freeze the upstream code for both nibbles.
            if (pass_q) begin
              byte_n = char;
              pass_n = 1'b0;
            end
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        PH_EHIGH: begin
          if (cnt_q == '0) begin
            phase_n  = PH_HOLD;
            cnt_n    = CNT_W'(T_HOLD - 1);
            enable_n = 1'b0;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        PH_HOLD: begin
          if (cnt_q == '0) begin
            if (state_q == S_INIT_NIB || !upper_q) begin
              phase_n = PH_WAIT;
              cnt_n   = wait_len(state_q, item_q);
            end else begin
              phase_n = PH_GAP;
              cnt_n   = CNT_W'(T_GAP - 1);
            end
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        PH_GAP: begin
          if (cnt_q == '0) begin
            phase_n = PH_SETUP;
            cnt_n   = CNT_W'(T_SETUP - 1);
            upper_n = 1'b0;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        PH_WAIT: begin
          if (cnt_q == '0) begin
            launch = 1'b1;
            case (state_q)
              S_INIT_NIB: begin
                tgt_state = (item_q == 4'd3) ? S_CFG_BYTE : S_INIT_NIB;
                tgt_item  = (item_q == 4'd3) ? 4'd0 : item_q + 4'd1;
              end
              S_CFG_BYTE: begin
                tgt_state = (item_q == 4'd3) ? S_ADDR1 : S_CFG_BYTE;
                tgt_item  = (item_q == 4'd3) ? 4'd0 : item_q + 4'd1;
              end
              S_ADDR1: begin
                tgt_state = S_LINE1;
                tgt_item  = 4'd0;
              end
              S_LINE1: begin
                tgt_state = (item_q == 4'hF) ? S_ADDR2 : S_LINE1;
                tgt_item  = (item_q == 4'hF) ? 4'd0 : item_q + 4'd1;
              end
              S_ADDR2: begin
                tgt_state = S_LINE2;
                tgt_item  = 4'd0;
              end
              S_LINE2: begin
                if (item_q == 4'hF) begin
                  launch       = 1'b0;
                  state_n      = S_FRAME_END;
                  frame_done_n = 1'b1;
                end else begin
                  tgt_item = item_q + 4'd1;
                end
              end
              default: launch = 1'b0;
            endcase
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        default: phase_n = PH_WAIT;
      endcase
    end

    // Start of a new write: first SETUP cycle of its upper (or only) nibble.
    if (launch) begin
      state_n = tgt_state;
      item_n  = tgt_item;
      phase_n = PH_SETUP;
      cnt_n   = CNT_W'(T_SETUP - 1);
      upper_n = 1'b1;
      rs_n    = (tgt_state == S_LINE1) || (tgt_state == S_LINE2);
      pass_n  = (tgt_state == S_LINE1) || (tgt_state == S_LINE2);
      byte_n  = cmd_byte(tgt_state, tgt_item);
      if (tgt_state == S_LINE1) index_n = {4'h0, tgt_item};
      if (tgt_state == S_LINE2) index_n = {4'h4, tgt_item};
      if (tgt_state == S_ADDR1) init_done_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PWR_WAIT;
      phase_q      <= PH_WAIT;
      cnt_q        <= CNT_W'(T_PWR - 1);
      item_q       <= 4'd0;
      upper_q      <= 1'b1;
      pass_q       <= 1'b0;
      rs_q         <= 1'b0;
      enable_q     <= 1'b0;
      byte_q       <= 8'h00;
      index_q      <= 8'h00;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      phase_q      <= phase_n;
      cnt_q        <= cnt_n;
      item_q       <= item_n;
      upper_q      <= upper_n;
      pass_q       <= pass_n;
      rs_q         <= rs_n;
      enable_q     <= enable_n;
      byte_q       <= byte_n;
      index_q      <= index_n;
      init_done_q  <= init_done_n;
      frame_done_q <= frame_done_n;
    end
  end

  // During the upper-nibble setup of a character the code is still settling,
  // so the pins follow upstream directly until it is frozen into byte_q.
  assign lcd_data   = pass_q ? char[7:4] : (upper_q ? byte_q[7:4] : byte_q[3:0]);
  assign rs         = rs_q;
  assign rw         = 1'b0;
  assign enable     = enable_q;
  assign index      = index_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_driver.sv
// Directed bench for lcd_refresh_driver with shortened timing parameters.
module tb_lcd_refresh_driver;

  localparam int T_PWR   = 20;
  localparam int T_INIT1 = 10;
  localparam int T_INIT2 = 5;
  localparam int T_CMD   = 4;
  localparam int T_CLEAR = 6;
  localparam int T_SETUP = 2;
  localparam int T_EHIGH = 12;
  localparam int T_HOLD  = 1;
  localparam int T_GAP   = 3;
  localparam int FRAME   = 34 * 37;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char;
  logic [7:0] index;
  logic       rs, rw, enable, init_done, frame_done;
  logic [3:0] lcd_data;
  logic       ovr_on = 1'b0;
  logic [7:0] ovr_val = 8'h41;

  lcd_refresh_driver #(
    .T_PWR(T_PWR), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
    .T_CLEAR(T_CLEAR), .T_SETUP(T_SETUP), .T_EHIGH(T_EHIGH), .T_HOLD(T_HOLD),
    .T_GAP(T_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .char(char), .index(index), .rs(rs), .rw(rw),
    .enable(enable), .lcd_data(lcd_data), .init_done(init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Upstream character map: code = index + 0x20, optionally overridden at index 7.
  assign char = (ovr_on && index == 8'h07) ? ovr_val : index + 8'h20;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  int         cyc = 0;
  int         last_chg = 0, rise_cyc = 0, fall_cyc = -100, init_rise = 0;
  int         rw_bad = 0, stab_bad = 0, setup_bad = 0, width_bad = 0;
  int         fd_wide_bad = 0, id_drop_bad = 0;
  logic       prev_en = 1'b0, prev_fd = 1'b0, prev_id = 1'b0;
  logic [4:0] prev_rd = 5'd0;
  int         nib_cyc[$];
  logic [4:0] nib_rd[$];
  logic [7:0] nib_idx[$];
  int         fd_cyc[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      prev_en  = 1'b0;
      prev_fd  = 1'b0;
      prev_id  = 1'b0;
      prev_rd  = {rs, lcd_data};
      last_chg = cyc;
      fall_cyc = -100;
    end else begin
      if (rw !== 1'b0) rw_bad++;
      if ({rs, lcd_data} !== prev_rd) begin
        if (enable || (cyc - fall_cyc < T_HOLD)) stab_bad++;
        last_chg = cyc;
      end
      if (enable && !prev_en) begin
        if (cyc - last_chg < T_SETUP) setup_bad++;
        rise_cyc = cyc;
        nib_cyc.push_back(cyc);
        nib_rd.push_back({rs, lcd_data});
        nib_idx.push_back(index);
      end
      if (!enable && prev_en) begin
        if (cyc - rise_cyc != T_EHIGH) width_bad++;
        fall_cyc = cyc;
      end
      if (frame_done && !prev_fd) fd_cyc.push_back(cyc);
      if (frame_done && prev_fd) fd_wide_bad++;
      if (init_done && !prev_id) init_rise = cyc;
      if (!init_done && prev_id) id_drop_bad++;
      prev_en = enable;
      prev_fd = frame_done;
      prev_id = init_done;
      prev_rd = {rs, lcd_data};
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_nibs(input int n, input int budget);
    for (int i = 0; i < budget && nib_rd.size() < n; i++) tick();
    if (nib_rd.size() < n) check("nib_timeout", nib_rd.size(), n);
  endtask

  // Init nibbles 3,3,3,2 then 28/06/0C/01 and the first 0x80; gaps are rise-to-rise.
  task automatic check_init(input int rel);
    logic [3:0] exp_nib [14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0,
                                 4'h6, 4'h0, 4'hC, 4'h0, 4'h1, 4'h8, 4'h0};
    int         exp_gap [14] = '{22, 25, 20, 19, 19, 18, 19, 18, 19, 18, 19, 18, 25, 18};
    if (nib_rd.size() >= 14) begin
      for (int i = 0; i < 14; i++) begin
        check($sformatf("init%0d_rd", i), nib_rd[i], {1'b0, exp_nib[i]});
        check($sformatf("init%0d_gap", i),
              nib_cyc[i] - ((i == 0) ? rel : nib_cyc[i-1]), exp_gap[i]);
      end
      check("init_done_rise", init_rise, nib_cyc[12] - T_SETUP);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_enable", enable, 1'b0);
    check("rst_rs", rs, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_data", lcd_data, 4'h0);
    check("rst_index", index, 8'h00);
    check("rst_init_done", init_done, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);

    begin
      int rel;
      rel = cyc;
      rst_n = 1'b1;
      wait_nibs(12 + 68 * 3 + 1, 8000);
      check_init(rel);
    end

    // Three refresh frames: commands, characters, index and spacing
    if (nib_rd.size() >= 12 + 68 * 3 + 1) begin
      for (int f = 0; f < 3; f++) begin
        for (int j = 0; j < 68; j++) begin
          int         q, k;
          logic [7:0] ch, eix;
          logic [4:0] erd;
          q = 12 + 68 * f + j;
          if (j < 2) begin
            erd = {1'b0, (j == 0) ? 4'h8 : 4'h0};
            eix = (f == 0) ? 8'h00 : 8'h4F;
          end else if (j < 34) begin
            k   = (j - 2) / 2;
            ch  = 8'h20 + 8'(k);
            erd = {1'b1, (j % 2 == 0) ? ch[7:4] : ch[3:0]};
            eix = 8'(k);
          end else if (j < 36) begin
            erd = {1'b0, (j == 34) ? 4'hC : 4'h0};
            eix = 8'h0F;
          end else begin
            k   = (j - 36) / 2;
            ch  = 8'h60 + 8'(k);
            erd = {1'b1, (j % 2 == 0) ? ch[7:4] : ch[3:0]};
            eix = 8'h40 + 8'(k);
          end
          check($sformatf("f%0d_n%0d_rd", f, j), nib_rd[q], erd);
          check($sformatf("f%0d_n%0d_idx", f, j), nib_idx[q], eix);
          if (!(f == 0 && j == 0))
            check($sformatf("f%0d_n%0d_gap", f, j), nib_cyc[q] - nib_cyc[q-1],
                  (j % 2 == 0) ? 19 : 18);
        end
      end
      check("frame_done_count", fd_cyc.size(), 3);
      if (fd_cyc.size() >= 3) begin
        for (int f = 0; f < 3; f++)
          check($sformatf("frame_done%0d_pos", f), fd_cyc[f], nib_cyc[12 + 68 * (f + 1)] - 3);
        check("frame_spacing01", fd_cyc[1] - fd_cyc[0], FRAME);
        check("frame_spacing12", fd_cyc[2] - fd_cyc[1], FRAME);
      end
    end
    check("init_done_held", init_done, 1'b1);

    // Character changes after the upper-nibble sample must not reach the lower nibble
    ovr_on  = 1'b1;
    ovr_val = 8'h41;
    for (int i = 0; i < 3000 && !(enable && index == 8'h07); i++) tick();
    check("chg_upper_seen", enable && index == 8'h07, 1'b1);
    check("chg_upper_data", {rs, lcd_data}, 5'h14);
    ovr_val = 8'h5A;
    for (int i = 0; i < 100 && enable; i++) tick();
    for (int i = 0; i < 100 && !enable; i++) tick();
    check("chg_lower_seen", enable, 1'b1);
    check("chg_lower_data", {rs, lcd_data}, 5'h11);
    ovr_on = 1'b0;

    // Asynchronous reset while E is high during line 2
    for (int i = 0; i < 3000 && !(enable && rs && index[6]); i++) tick();
    check("line2_pulse_seen", enable && rs && index[6], 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_enable", enable, 1'b0);
    check("midrst_rs", rs, 1'b0);
    check("midrst_data", lcd_data, 4'h0);
    check("midrst_index", index, 8'h00);
    check("midrst_init_done", init_done, 1'b0);
    tick();
    tick();
    nib_cyc.delete();
    nib_rd.delete();
    nib_idx.delete();
    fd_cyc.delete();
    begin
      int rel;
      rel = cyc;
      rst_n = 1'b1;
      wait_nibs(14, 2000);
      check_init(rel);
    end

    check("rw_always_zero", rw_bad, 0);
    check("data_stable", stab_bad, 0);
    check("data_setup", setup_bad, 0);
    check("enable_width", width_bad, 0);
    check("frame_done_1cyc", fd_wide_bad, 0);
    check("init_done_no_drop", id_drop_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
